// File: rtl/boot_copier.sv
// ---------------------------------------------------------------------------
// boot_copier
//   Copies WORDS 16-bit words from a ROM to a RAM after a start request.
//   Each word is read in one cycle (ROM data is valid with the address) and
//   then written, holding the write request until the RAM accepts it.
//   Once the copy is done, the block stays in DONE until reset.
//
//   Optional feature (macro BOOT_CHECKSUM_EN):
//     A modulo-2^16 sum of words 0..WORDS-2 is compared with the last word.
//     On a mismatch, err is set and stays set until reset. When the macro is
//     undefined, err is tied to 0.
//
// Parameters
//   WORDS      number of words to copy (2..4096)
//   SRC_BASE   first ROM word address
//   DST_BASE   first RAM word address
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        level request to start the copy (sampled in IDLE only)
//   rom_address  ROM word address (0 outside READ)
//   rom_be       ROM byte enables (2'b11 in READ)
//   rom_ce       ROM chip enable (1 in READ)
//   rom_data     ROM read data
//   ram_addr     RAM word address (holds its last value outside WRITE)
//   ram_wdata    RAM write data (holds its last value outside WRITE)
//   ram_we       RAM write request (1 in WRITE)
//   ram_ready    RAM accept; a write completes when ram_we & ram_ready
//   busy         copy in progress (READ, WRITE, CHECK)
//   done         copy finished, sticky until reset
//   err          checksum mismatch, sticky until reset
// ---------------------------------------------------------------------------
module boot_copier #(
  parameter int          WORDS    = 4096,
  parameter logic [17:0] SRC_BASE = 18'h00000,
  parameter logic [17:0] DST_BASE = 18'h00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [17:0] rom_address,
  output logic [1:0]  rom_be,
  output logic        rom_ce,
  input  logic [15:0] rom_data,
  output logic [17:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_we,
  input  logic        ram_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int            IW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_index;
  logic [15:0]   r_buf;
  logic [17:0]   r_ram_addr;
  logic          w_accept;
  logic          w_last;

  assign w_accept = (r_state == S_WRITE) && ram_ready;
  assign w_last   = (r_index == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_READ;
      S_READ:  w_next = S_WRITE;
      S_WRITE: if (ram_ready) w_next = w_last ? S_CHECK : S_READ;
      S_CHECK: w_next = S_DONE;
      S_DONE:  w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // The buffer doubles as the RAM write data: it is loaded at the end of
  // READ together with the RAM address, so both stay stable throughout
  // WRITE and keep their values afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_index    <= '0;
      r_buf      <= '0;
      r_ram_addr <= '0;
    end else begin
      if (r_state == S_IDLE && start) r_index <= '0;
      if (r_state == S_READ) begin
        r_buf      <= rom_data;
        r_ram_addr <= DST_BASE + 18'(r_index);
      end
      if (w_accept && !w_last) r_index <= r_index + IW'(1);
    end
  end

`ifdef BOOT_CHECKSUM_EN
  logic [15:0] r_sum;
  logic        r_err;

  // The last word is the expected checksum, so it is not added to the sum.
  // CHECK compares the sum with it while the last word is still in r_buf.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_accept && !w_last) r_sum <= r_sum + r_buf;
      if (r_state == S_CHECK && r_sum != r_buf) r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign rom_ce      = (r_state == S_READ);
  assign rom_be      = (r_state == S_READ) ? 2'b11 : 2'b00;
  assign rom_address = (r_state == S_READ) ? (SRC_BASE + 18'(r_index)) : 18'h0;
  assign ram_we      = (r_state == S_WRITE);
  assign ram_addr    = r_ram_addr;
  assign ram_wdata   = r_buf;
  assign busy        = (r_state == S_READ) || (r_state == S_WRITE) || (r_state == S_CHECK);
  assign done        = (r_state == S_DONE);

endmodule

// File: doc/boot_copier.md
BOOT_COPIER -- requirements
Module: boot_copier

Interface
REQ-001 Parameter WORDS, default 4096, number of 16-bit words to copy (range 2..4096).
REQ-002 Parameter SRC_BASE, default 18'h00000, first ROM word address.
REQ-003 Parameter DST_BASE, default 18'h00000, first RAM word address.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  level request to begin the copy; sampled in IDLE only.
REQ-007 rom_address  output  18  ROM word address.
REQ-008 rom_be  output  2  ROM byte enable.
REQ-009 rom_ce  output  1  ROM chip enable.
REQ-010 rom_data  input  16  ROM read data; valid in the same cycle as the address.
REQ-011 ram_addr  output  18  RAM word address.
REQ-012 ram_wdata  output  16  RAM write data.
REQ-013 ram_we  output  1  RAM write request.
REQ-014 ram_ready  input  1  RAM accept; a write completes in a cycle where ram_we and ram_ready are both 1.
REQ-015 busy  output  1  copy in progress.
REQ-016 done  output  1  copy finished; sticky until reset.
REQ-017 err  output  1  checksum mismatch (see Configuration).

Function
REQ-018 The FSM SHALL have states IDLE, READ, WRITE, CHECK and DONE, with all outputs decoded from registered state and data (Moore).
REQ-019 IDLE: when start=1, go to READ with index=0; otherwise stay.
REQ-020 READ: rom_ce=1, rom_be=2'b11, rom_address=SRC_BASE+index; latch rom_data into the data buffer at the clock edge; go to WRITE (1 cycle).
REQ-021 WRITE: ram_we=1, ram_addr=DST_BASE+index, ram_wdata=buffer, all held stable until ram_ready=1.
REQ-022 On an accepted write: if index==WORDS-1, go to CHECK; otherwise increment index and go to READ.
REQ-023 CHECK: take one cycle, then go to DONE.
REQ-024 DONE: done=1 and busy=0; stay until reset; ignore start.
REQ-025 busy SHALL be 1 in READ, WRITE and CHECK, and 0 otherwise.
REQ-026 Outside READ: rom_ce=0, rom_be=2'b00 and rom_address=0.
REQ-027 Outside WRITE: ram_we=0; ram_addr and ram_wdata hold their last values.
REQ-028 Address arithmetic SHALL be 18-bit modulo 2^18, so base+index wraps with no error.
REQ-029 Minimum throughput SHALL be 2 cycles per word when ram_ready=1.
REQ-030 start held high after DONE SHALL NOT restart the copy.

Reset
REQ-031 Asserting rst_n=0 at any time, including mid-copy, SHALL immediately force IDLE and set index=0, buffer=0, checksum=0, busy=0, done=0, err=0, rom_ce=0, rom_be=0, rom_address=0, ram_we=0, ram_addr=0 and ram_wdata=0.
REQ-032 After rst_n is released, the copy SHALL restart from word 0 on the next start.

Configuration
REQ-033 Macro BOOT_CHECKSUM_EN defined: a 16-bit modulo-2^16 sum SHALL accumulate words 0..WORDS-2 on each accepted write.
REQ-034 With the macro defined, in CHECK err SHALL be set to 1 if the sum differs from word WORDS-1; err is sticky until reset.
REQ-035 Macro undefined: there is no accumulator, err is tied to 0, and CHECK still takes 1 cycle.

Verification
REQ-036 WORDS=4, ROM {0001,0002,0003,0006}, ram_ready=1, pulse start -> four RAM writes to addresses 0..3 with those values; done=1 at cycle 9 after start is sampled; err=0.
REQ-037 Same as REQ-036 but ROM word 3 = 0007 with BOOT_CHECKSUM_EN -> done=1 and err=1; without the macro -> err=0.
REQ-038 ram_ready held 0 for 3 cycles on word 1 -> ram_we, ram_addr and ram_wdata stay stable for 4 cycles; no word is skipped or duplicated.
REQ-039 SRC_BASE=18'h3FFFE, WORDS=4 -> rom_address sequence 3FFFE, 3FFFF, 00000, 00001.
REQ-040 rst_n pulsed low during WRITE of word 2 -> all outputs 0 in the same cycle; a new start copies from word 0.
REQ-041 start held high through DONE for 20 cycles -> no further rom_ce or ram_we activity; done stays 1.
